// File: rtl/conv_output_streamer.sv
// ---------------------------------------------------------------------------
// conv_output_streamer
//
// Reads the packed 8-bit feature map from the convolution output SRAM and
// streams it one pixel per cycle on a valid/ready byte interface. Each 16-bit
// SRAM word holds two pixels: [15:8] is the left/even pixel and [7:0] is the
// right/odd pixel. The left pixel is sent first.
//
// The block is started by a run pulse once the convolution engine is idle,
// and it owns the SRAM read port while busy.
//
// Ports
//   clk                       clock, all state on rising edge
//   reset_b                   asynchronous active-low reset
//   streamer_run              start request, sampled in IDLE only
//   streamer_busy             high from the cycle after run is accepted
//                             through the DONE cycle
//   streamer_done             one-cycle completion pulse
//   output_sram_read_address  registered SRAM read address
//   output_sram_read_data     SRAM read data, valid one clock after the
//                             address is registered
//   pixel_valid / pixel_ready stream handshake
//   pixel_data                pixel byte, passed through unmodified
//   pixel_last                marks the final pixel of the map
//   pixel_row_end             marks the final pixel of each map row
//
// State table
//   state | meaning
//   IDLE  | waiting for streamer_run
//   FETCH | capture word 0, point address at word 1
//   HI    | present left pixel of the held word
//   LO    | present right pixel, capture the next word on transfer
//   DONE  | one-cycle completion pulse, release busy
// ---------------------------------------------------------------------------
module conv_output_streamer #(
    parameter int NUM_WORDS     = 98,
    parameter int WORDS_PER_ROW = 7,
    parameter int ADDR_W        = 12
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              streamer_run,
    output logic              streamer_busy,
    output logic              streamer_done,
    output logic [ADDR_W-1:0] output_sram_read_address,
    input  logic [15:0]       output_sram_read_data,
    output logic              pixel_valid,
    input  logic              pixel_ready,
    output logic [7:0]        pixel_data,
    output logic              pixel_last,
    output logic              pixel_row_end
);

    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int COL_W = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(WORDS_PER_ROW - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_HI    = 3'd2,
        ST_LO    = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic               busy_q, busy_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [15:0]        word_q, word_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    // Column-within-row counter; avoids a modulo on the word index.
    logic [COL_W-1:0]   col_q, col_d;

    logic               last_word;
    logic               more_words;
    logic               row_end_word;

    assign last_word    = (idx_q == LAST_IDX);
    // The address may only move past the word being captured when a further
    // word exists; otherwise it stays parked on the final word.
    assign more_words   = ((int'(idx_q) + 2) < NUM_WORDS);
    assign row_end_word = (col_q == LAST_COL);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            addr_q  <= '0;
            word_q  <= '0;
            idx_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            addr_q  <= addr_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            col_q   <= col_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath update
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        addr_d  = addr_q;
        word_d  = word_q;
        idx_d   = idx_q;
        col_d   = col_q;

        case (state_q)
            ST_IDLE: begin
                if (streamer_run) begin
                    addr_d  = '0;
                    idx_d   = '0;
                    col_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_FETCH;
                end
            end

            ST_FETCH: begin
                // Address 0 was registered on the run edge, so word 0 is
                // on the read bus now.
                word_d = output_sram_read_data;
                if (NUM_WORDS > 1) begin
                    addr_d = ADDR_W'(1);
                end
                state_d = ST_HI;
            end

            ST_HI: begin
                if (pixel_ready) begin
                    state_d = ST_LO;
                end
            end

            ST_LO: begin
                if (pixel_ready) begin
                    if (last_word) begin
                        state_d = ST_DONE;
                    end else begin
                        // HI lasted at least one cycle since the address
                        // moved, so the next word is already valid here.
                        word_d = output_sram_read_data;
                        idx_d  = idx_q + IDX_W'(1);
                        col_d  = row_end_word ? '0 : (col_q + COL_W'(1));
                        if (more_words) begin
                            addr_d = addr_q + ADDR_W'(1);
                        end
                        state_d = ST_HI;
                    end
                end
            end

            ST_DONE: begin
                busy_d  = 1'b0;
                addr_d  = '0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from state and registers only
    // ------------------------------------------------------------------
    always_comb begin
        pixel_valid   = 1'b0;
        pixel_data    = 8'h00;
        pixel_last    = 1'b0;
        pixel_row_end = 1'b0;
        streamer_done = 1'b0;

        case (state_q)
            ST_HI: begin
                pixel_valid = 1'b1;
                pixel_data  = word_q[15:8];
            end
            ST_LO: begin
                pixel_valid   = 1'b1;
                pixel_data    = word_q[7:0];
                pixel_last    = last_word;
                pixel_row_end = row_end_word;
            end
            ST_DONE: begin
                streamer_done = 1'b1;
            end
            default: begin
                pixel_valid = 1'b0;
            end
        endcase
    end

    assign streamer_busy            = busy_q;
    assign output_sram_read_address = addr_q;

endmodule
